// File: rtl/vec_fork.sv
// rtl/vec_fork.sv - one-to-two vector stream fork with registered output stage
// Optional one-entry input skid buffer enabled by defining VEC_FORK_SKID_EN.
module vec_fork #(
    parameter int BW          = 8,
    parameter int VECTOR_SIZE = 13
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [VECTOR_SIZE*BW-1:0] data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic [VECTOR_SIZE*BW-1:0] data1_o,
    output logic                      valid1_o,
    output logic                      last1_o,
    input  logic                      ready1_i,
    output logic [VECTOR_SIZE*BW-1:0] data2_o,
    output logic                      valid2_o,
    output logic                      last2_o,
    input  logic                      ready2_i
);

    localparam int DW = VECTOR_SIZE * BW;

    logic [DW-1:0] data_q;
    logic          last_q;
    logic          pend1;
    logic          pend2;
    logic          acc;
    logic          tx1;
    logic          tx2;
    logic          done;

    // done: the output stage is empty or both consumers take it this cycle
    assign done = (!pend1 || ready1_i) && (!pend2 || ready2_i);
    assign acc  = valid_i && ready_o;
    assign tx1  = pend1 && ready1_i;
    assign tx2  = pend2 && ready2_i;

    assign data1_o  = data_q;
    assign data2_o  = data_q;
    assign last1_o  = last_q;
    assign last2_o  = last_q;
    assign valid1_o = pend1;
    assign valid2_o = pend2;

`ifdef VEC_FORK_SKID_EN
    logic [DW-1:0] skid_data;
    logic          skid_last;
    logic          skid_full;

    // Registered ready breaks the combinational path from the consumers.
    assign ready_o = !skid_full;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q    <= '0;
            last_q    <= 1'b0;
            pend1     <= 1'b0;
            pend2     <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
            skid_full <= 1'b0;
        end else if (done && skid_full) begin
            data_q    <= skid_data;
            last_q    <= skid_last;
            pend1     <= 1'b1;
            pend2     <= 1'b1;
            skid_full <= 1'b0;
        end else if (acc && done) begin
            data_q <= data_i;
            last_q <= last_i;
            pend1  <= 1'b1;
            pend2  <= 1'b1;
        end else begin
            if (acc) begin
                skid_data <= data_i;
                skid_last <= last_i;
                skid_full <= 1'b1;
            end
            if (tx1) pend1 <= 1'b0;
            if (tx2) pend2 <= 1'b0;
        end
    end
`else
    assign ready_o = done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q <= '0;
            last_q <= 1'b0;
            pend1  <= 1'b0;
            pend2  <= 1'b0;
        end else if (acc) begin
            data_q <= data_i;
            last_q <= last_i;
            pend1  <= 1'b1;
            pend2  <= 1'b1;
        end else begin
            if (tx1) pend1 <= 1'b0;
            if (tx2) pend2 <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vec_fork.sv
// tb/tb_vec_fork.sv - directed and scoreboard checks for vec_fork
// Define VEC_FORK_SKID_EN to also exercise the skid buffer.
module tb_vec_fork;

    localparam int DW = 8 * 13;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          last_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data1_o;
    logic          valid1_o;
    logic          last1_o;
    logic          ready1_i = 1'b0;
    logic [DW-1:0] data2_o;
    logic          valid2_o;
    logic          last2_o;
    logic          ready2_i = 1'b0;

    int checks = 0;
    int failures = 0;

    vec_fork #(.BW(8), .VECTOR_SIZE(13)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .last1_o  (last1_o),
        .ready1_i (ready1_i),
        .data2_o  (data2_o),
        .valid2_o (valid2_o),
        .last2_o  (last2_o),
        .ready2_i (ready2_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        step();
        checks++;
        if ({valid1_o, valid2_o, ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL reset_ctrl got v1v2rdy=%b want 001", {valid1_o, valid2_o, ready_o});
        end
        checks++;
        if (data1_o !== '0 || data2_o !== '0 || last1_o !== 1'b0 || last2_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got d1=%h d2=%h l1=%b l2=%b want zeros", data1_o, data2_o, last1_o, last2_o);
        end
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        ready1_i = 1'b1;
        ready2_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            data_i  = DW'(k);
            last_i  = (k == 5);
            valid_i = 1'b1;
            #1;
            checks++;
            if (ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready k=%0d got %b want 1", k, ready_o);
            end
            step();
            exp = DW'(k);
            checks++;
            if (valid1_o !== 1'b1 || valid2_o !== 1'b1 || data1_o !== exp || data2_o !== exp) begin
                failures++;
                $display("FAIL b2b_data k=%0d got v=%b%b d1=%h d2=%h want v=11 d=%h", k, valid1_o, valid2_o, data1_o, data2_o, exp);
            end
            checks++;
            if (last1_o !== (k == 5) || last2_o !== (k == 5)) begin
                failures++;
                $display("FAIL b2b_last k=%0d got %b%b want %b", k, last1_o, last2_o, (k == 5));
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got v=%b%b want 00", valid1_o, valid2_o);
        end
    endtask

    task automatic test_stall_one();
        ready1_i = 1'b1;
        ready2_i = 1'b0;
        data_i   = DW'(8'hAA);
        valid_i  = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ready2_i = (i == 3);
            #1;
            checks++;
            if (valid1_o !== (i == 0) || valid2_o !== 1'b1 || data2_o !== DW'(8'hAA)) begin
                failures++;
                $display("FAIL stall_out i=%0d got v1=%b v2=%b d2=%h want v1=%b v2=1 d2=aa", i, valid1_o, valid2_o, data2_o, (i == 0));
            end
`ifndef VEC_FORK_SKID_EN
            checks++;
            if (ready_o !== (i == 3)) begin
                failures++;
                $display("FAIL stall_ready i=%0d got %b want %b", i, ready_o, (i == 3));
            end
`endif
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_after i=%0d got v=%b%b want 00", i, valid1_o, valid2_o);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q1_d[$];
        logic [DW-1:0] q2_d[$];
        logic          q1_l[$];
        logic          q2_l[$];
        logic [DW-1:0] ed;
        logic          el;
        int            sent = 0;
        int            cyc = 0;
        while (cyc < 5000 && !(sent == 200 && q1_d.size() == 0 && q2_d.size() == 0)) begin
            cyc++;
            if (sent < 200) begin
                valid_i  = ($urandom_range(0, 3) != 0);
                data_i   = {$urandom, $urandom, $urandom, $urandom};
                last_i   = $urandom_range(0, 1);
                ready1_i = $urandom_range(0, 1);
                ready2_i = $urandom_range(0, 1);
            end else begin
                valid_i  = 1'b0;
                ready1_i = 1'b1;
                ready2_i = 1'b1;
            end
            #1;
`ifndef VEC_FORK_SKID_EN
            if (ready_o !== ((!valid1_o || ready1_i) && (!valid2_o || ready2_i))) begin
                checks++;
                failures++;
                $display("FAIL rand_ready cyc=%0d got %b", cyc, ready_o);
            end
`endif
            if (valid1_o && ready1_i) begin
                checks++;
                if (q1_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_out1 cyc=%0d got unexpected %h want none", cyc, data1_o);
                end else begin
                    ed = q1_d.pop_front();
                    el = q1_l.pop_front();
                    if (data1_o !== ed || last1_o !== el) begin
                        failures++;
                        $display("FAIL rand_out1 cyc=%0d got %h/%b want %h/%b", cyc, data1_o, last1_o, ed, el);
                    end
                end
            end
            if (valid2_o && ready2_i) begin
                checks++;
                if (q2_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_out2 cyc=%0d got unexpected %h want none", cyc, data2_o);
                end else begin
                    ed = q2_d.pop_front();
                    el = q2_l.pop_front();
                    if (data2_o !== ed || last2_o !== el) begin
                        failures++;
                        $display("FAIL rand_out2 cyc=%0d got %h/%b want %h/%b", cyc, data2_o, last2_o, ed, el);
                    end
                end
            end
            if (valid_i && ready_o) begin
                q1_d.push_back(data_i);
                q2_d.push_back(data_i);
                q1_l.push_back(last_i);
                q2_l.push_back(last_i);
                sent++;
            end
            step();
        end
        valid_i = 1'b0;
        checks++;
        if (sent != 200 || q1_d.size() != 0 || q2_d.size() != 0) begin
            failures++;
            $display("FAIL rand_drain got sent=%0d left1=%0d left2=%0d want 200/0/0", sent, q1_d.size(), q2_d.size());
        end
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL rand_idle got v=%b%b want 00", valid1_o, valid2_o);
        end
    endtask

    task automatic test_reset_mid();
        ready1_i = 1'b1;
        ready2_i = 1'b0;
        data_i   = DW'(8'h55);
        valid_i  = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got v=%b%b want 01", valid1_o, valid2_o);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({valid1_o, valid2_o, ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_async got v1v2rdy=%b want 001", {valid1_o, valid2_o, ready_o});
        end
        #1;
        rstn_i = 1'b1;
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_released got v=%b%b want 00", valid1_o, valid2_o);
        end
        ready2_i = 1'b1;
        data_i   = DW'(8'h33);
        valid_i  = 1'b1;
        step();
        valid_i = 1'b0;
        checks++;
        if (valid1_o !== 1'b1 || valid2_o !== 1'b1 || data1_o !== DW'(8'h33) || data2_o !== DW'(8'h33)) begin
            failures++;
            $display("FAIL rstmid_next got v=%b%b d1=%h d2=%h want 11 33", valid1_o, valid2_o, data1_o, data2_o);
        end
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_done got v=%b%b want 00", valid1_o, valid2_o);
        end
    endtask

    task automatic test_replace();
        ready1_i = 1'b1;
        ready2_i = 1'b1;
        data_i   = DW'(8'h0F);
        valid_i  = 1'b1;
        step();
        data_i = DW'(8'h10);
        #1;
        checks++;
        if (ready_o !== 1'b1 || data1_o !== DW'(8'h0F) || valid1_o !== 1'b1 || valid2_o !== 1'b1) begin
            failures++;
            $display("FAIL replace_pre got rdy=%b v=%b%b d1=%h want 1 11 0f", ready_o, valid1_o, valid2_o, data1_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (valid1_o !== 1'b1 || valid2_o !== 1'b1 || data1_o !== DW'(8'h10) || data2_o !== DW'(8'h10)) begin
            failures++;
            $display("FAIL replace_next got v=%b%b d1=%h d2=%h want 11 10", valid1_o, valid2_o, data1_o, data2_o);
        end
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL replace_idle got v=%b%b want 00", valid1_o, valid2_o);
        end
    endtask

`ifdef VEC_FORK_SKID_EN
    task automatic test_skid();
        ready1_i = 1'b0;
        ready2_i = 1'b0;
        data_i   = DW'(8'h21);
        valid_i  = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL skid_rdy0 got %b want 1", ready_o);
        end
        step();
        data_i = DW'(8'h22);
        checks++;
        if (ready_o !== 1'b1 || data1_o !== DW'(8'h21)) begin
            failures++;
            $display("FAIL skid_rdy1 got rdy=%b d1=%h want 1 21", ready_o, data1_o);
        end
        step();
        valid_i = 1'b0;
        step();
        checks++;
        if (ready_o !== 1'b0 || data1_o !== DW'(8'h21) || valid1_o !== 1'b1 || valid2_o !== 1'b1) begin
            failures++;
            $display("FAIL skid_full got rdy=%b v=%b%b d1=%h want 0 11 21", ready_o, valid1_o, valid2_o, data1_o);
        end
        ready1_i = 1'b1;
        ready2_i = 1'b1;
        step();
        checks++;
        if (ready_o !== 1'b1 || data1_o !== DW'(8'h22) || data2_o !== DW'(8'h22) || valid1_o !== 1'b1 || valid2_o !== 1'b1) begin
            failures++;
            $display("FAIL skid_drain got rdy=%b v=%b%b d1=%h d2=%h want 1 11 22", ready_o, valid1_o, valid2_o, data1_o, data2_o);
        end
        step();
        checks++;
        if (valid1_o !== 1'b0 || valid2_o !== 1'b0) begin
            failures++;
            $display("FAIL skid_idle got v=%b%b want 00", valid1_o, valid2_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_one();
        test_random();
        test_reset_mid();
        test_replace();
`ifdef VEC_FORK_SKID_EN
        test_skid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_fork.md
Name: vec_fork

Overview:
- Splits one valid/ready/last vector stream into two identical output streams, one per downstream consumer.
- Each input vector is delivered exactly once to each consumer; consumers may accept in different cycles.
- Used ahead of paired-operand stages, e.g. to feed one feature vector to two parallel datapaths that later rejoin.
- Registered output stage; 1-cycle latency; full throughput when both consumers are ready.

Parameters:
- BW, 8, bits per vector element.
- VECTOR_SIZE, 13, elements per vector; data width = VECTOR_SIZE*BW.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- data_i  input  VECTOR_SIZE*BW  input vector.
- valid_i  input  1  input vector valid.
- last_i  input  1  input end-of-frame marker, qualified by valid_i.
- ready_o  output  1  block accepts the input vector this cycle.
- data1_o  output  VECTOR_SIZE*BW  vector to consumer 1.
- valid1_o  output  1  consumer 1 vector pending.
- last1_o  output  1  end-of-frame to consumer 1.
- ready1_i  input  1  consumer 1 accepts.
- data2_o  output  VECTOR_SIZE*BW  vector to consumer 2.
- valid2_o  output  1  consumer 2 vector pending.
- last2_o  output  1  end-of-frame to consumer 2.
- ready2_i  input  1  consumer 2 accepts.

Behaviour:
- State: output register data_q and last_q; pending flags pend1 and pend2.
- data1_o = data2_o = data_q; last1_o = last2_o = last_q; valid1_o = pend1; valid2_o = pend2.
- Reset (rstn_i low, asynchronous): data_q=0, last_q=0, pend1=0, pend2=0. Hence valid1_o=valid2_o=0 and ready_o=1.
- Reset mid-operation discards any pending vector immediately; no partial delivery after reset release.
- Accept transfer: acc = valid_i & ready_o. Output transfers: tx1 = pend1 & ready1_i; tx2 = pend2 & ready2_i.
- done = (!pend1 | ready1_i) & (!pend2 | ready2_i). This is true when the output stage is empty or fully drains this cycle.
- ready_o = done (combinational from ready1_i/ready2_i in the base build).
- On acc: load data_q and last_q from the input; set pend1=1 and pend2=1 for the next cycle.
- Otherwise: clear pend1 on tx1 and pend2 on tx2 independently; data_q and last_q hold.
- A consumer that already accepted sees valid low until the next vector. It never receives a duplicate.
- Simultaneous accept and final drain in the same cycle: the new vector replaces the old. No bubble, throughput 1 vector/cycle.
- Latency: input accepted in cycle N appears on both outputs with valid high in cycle N+1.
- data_q and last_q are stable while either pend flag is set. valid is never deasserted before its transfer.
- last is forwarded unchanged to both outputs with its vector; it has no effect on control.
- No arithmetic. Outputs carry bit-exact copies of data_i.

Optional Feature:
- Macro: VEC_FORK_SKID_EN.
- Defined: adds a one-entry skid buffer (skid_data, skid_last, skid_full).
  - ready_o = !skid_full, a registered signal with no combinational path from ready1_i/ready2_i.
  - If acc occurs while done=0, the vector goes to the skid buffer.
  - When done=1 and skid_full=1, the skid entry moves to the output register (both pend flags set), skid_full clears, and ready_o rises the following cycle.
  - Order is preserved: input first, then skid, then output stage.
  - Reset clears skid_full.
  - Throughput with both consumers ready is still 1 vector/cycle.
- Undefined: no skid storage; ready_o = done as above.

Test Plan:
- Both ready held 1; send vectors 0x01..0x05 back-to-back with last on 0x05 -> each appears on both outputs exactly one cycle after acceptance. last1_o=last2_o=1 only with 0x05. ready_o stays 1 throughout.
- ready1_i=1, ready2_i=0 for 3 cycles, then 1; send 0xAA -> valid1_o pulses 1 cycle; valid2_o high for 4 cycles with 0xAA stable. ready_o=0 until consumer 2 accepts; 0xAA is never repeated on output 1.
- Alternating random stalls on both consumers over 200 random vectors -> scoreboard shows each vector exactly once per output, in order, with matching last.
- Assert rstn_i low while pend2=1 -> valid1_o, valid2_o go low asynchronously and ready_o=1. After release, the next vector 0x33 is delivered with no trace of the old one.
- Input 0x10 accepted in the same cycle the previous 0x0F drains from both outputs -> 0x10 is valid on both outputs in the next cycle with no idle cycle.
- VEC_FORK_SKID_EN defined; both consumers stalled; valid_i held with 0x21, 0x22 -> 0x21 goes to the output stage and 0x22 to the skid, then ready_o=0. After release, 0x21 then 0x22 are delivered in order, and ready_o returns to 1 one cycle after the skid empties.
